// File: rtl/vga_scanout_timing.sv
// VGA scan-out timing: lock-qualified raster counters, frame-buffer read requests and pipelined pixel output.
// Define VGA_TEST_PATTERN_EN to add a test_en input that replaces frame-buffer data with 8 vertical colour bars.
module vga_scanout_timing #(
  parameter int H_ACTIVE    = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter int LOCK_SETTLE = 16,
  parameter int RD_LATENCY  = 2,
  parameter int COLOR_W     = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 locked,
`ifdef VGA_TEST_PATTERN_EN
  input  logic                 test_en,
`endif
  output logic                 rd_req,
  output logic [9:0]           rd_x,
  output logic [9:0]           rd_y,
  input  logic [3*COLOR_W-1:0] rd_data,
  output logic                 vga_hs,
  output logic                 vga_vs,
  output logic                 vga_blank_n,
  output logic                 vga_sync_n,
  output logic [COLOR_W-1:0]   vga_r,
  output logic [COLOR_W-1:0]   vga_g,
  output logic [COLOR_W-1:0]   vga_b,
  output logic                 frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
  localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam int SW = $clog2(LOCK_SETTLE + 1);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(LOCK_SETTLE - 1);
  localparam int L = RD_LATENCY - 1;

  typedef enum logic [1:0] {WAIT_LOCK, SETTLE, RUN} state_t;

  state_t        state_q, state_d;
  logic [SW-1:0] settle_q, settle_d, settle_inc;
  logic          lk_meta, lk_s;
  logic [9:0]    h_cnt, v_cnt;
  logic          run, act0, hs0, vs0, first0, flush;
  logic          act_d [RD_LATENCY];
  logic          hs_d [RD_LATENCY];
  logic          vs_d [RD_LATENCY];
  logic          first_d [RD_LATENCY];
  logic [3*COLOR_W-1:0] pix;

  always_ff @(posedge clk) begin
    if (rst) begin
      lk_meta <= 1'b0;
      lk_s    <= 1'b0;
    end else begin
      lk_meta <= locked;
      lk_s    <= lk_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= WAIT_LOCK;
      settle_q <= '0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
    end
  end

  // RUN is entered once lk_s has been high for LOCK_SETTLE consecutive cycles.
  always_comb begin
    state_d    = state_q;
    settle_d   = settle_q;
    settle_inc = settle_q + SW'(1);
    case (state_q)
      WAIT_LOCK: begin
        settle_d = '0;
        if (lk_s) state_d = SETTLE;
      end
      SETTLE: begin
        if (!lk_s) begin
          state_d  = WAIT_LOCK;
          settle_d = '0;
        end else begin
          settle_d = settle_inc;
          if (settle_inc == SETTLE_LAST) state_d = RUN;
        end
      end
      RUN: begin
        if (!lk_s) state_d = WAIT_LOCK;
      end
      default: state_d = WAIT_LOCK;
    endcase
  end

  // Any departure from RUN drops the frame immediately and restarts at (0,0).
  assign flush = rst || (state_d != RUN);

  always_ff @(posedge clk) begin
    if (rst || state_q != RUN || state_d != RUN) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 10'd1;
    end else begin
      h_cnt <= h_cnt + 10'd1;
    end
  end

  always_comb begin
    run    = (state_q == RUN);
    act0   = run && (h_cnt < H_ACT) && (v_cnt < V_ACT);
    hs0    = !(run && (h_cnt >= HS_BEG) && (h_cnt < HS_END));
    vs0    = !(run && (v_cnt >= VS_BEG) && (v_cnt < VS_END));
    first0 = run && (h_cnt == '0) && (v_cnt == '0);
  end

  // Read port: rd_req is a strobe with no back-pressure; rd_data for a request
  // is sampled exactly RD_LATENCY cycles later and is don't-care otherwise.
  assign rd_x = h_cnt;
  assign rd_y = v_cnt;

`ifdef VGA_TEST_PATTERN_EN
  localparam logic [9:0] BAR_W = 10'(H_ACTIVE / 8);
  logic       tp_meta, tp_s;
  logic [9:0] x_d [RD_LATENCY];
  logic       tp_d [RD_LATENCY];
  logic [2:0] bar;

  always_ff @(posedge clk) begin
    if (rst) begin
      tp_meta <= 1'b0;
      tp_s    <= 1'b0;
    end else begin
      tp_meta <= test_en;
      tp_s    <= tp_meta;
    end
  end

  assign rd_req = act0 && !tp_s;

  always_ff @(posedge clk) begin
    if (flush) begin
      for (int i = 0; i < RD_LATENCY; i++) begin
        x_d[i]  <= '0;
        tp_d[i] <= 1'b0;
      end
    end else begin
      x_d[0]  <= h_cnt;
      tp_d[0] <= tp_s;
      for (int i = 1; i < RD_LATENCY; i++) begin
        x_d[i]  <= x_d[i-1];
        tp_d[i] <= tp_d[i-1];
      end
    end
  end

  always_comb begin
    pix = rd_data;
    bar = 3'(x_d[L] / BAR_W);
    if (tp_d[L]) pix = {{COLOR_W{bar[2]}}, {COLOR_W{bar[1]}}, {COLOR_W{bar[0]}}};
  end
`else
  assign rd_req = act0;

  always_comb begin
    pix = rd_data;
  end
`endif

  always_ff @(posedge clk) begin
    if (flush) begin
      for (int i = 0; i < RD_LATENCY; i++) begin
        act_d[i]   <= 1'b0;
        hs_d[i]    <= 1'b1;
        vs_d[i]    <= 1'b1;
        first_d[i] <= 1'b0;
      end
    end else begin
      act_d[0]   <= act0;
      hs_d[0]    <= hs0;
      vs_d[0]    <= vs0;
      first_d[0] <= first0;
      for (int i = 1; i < RD_LATENCY; i++) begin
        act_d[i]   <= act_d[i-1];
        hs_d[i]    <= hs_d[i-1];
        vs_d[i]    <= vs_d[i-1];
        first_d[i] <= first_d[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (flush) begin
      vga_hs      <= 1'b1;
      vga_vs      <= 1'b1;
      vga_blank_n <= 1'b0;
      frame_start <= 1'b0;
      {vga_r, vga_g, vga_b} <= '0;
    end else begin
      vga_hs      <= hs_d[L];
      vga_vs      <= vs_d[L];
      vga_blank_n <= act_d[L];
      frame_start <= first_d[L];
      if (act_d[L]) {vga_r, vga_g, vga_b} <= pix;
      else          {vga_r, vga_g, vga_b} <= '0;
    end
  end

  assign vga_sync_n = 1'b0;

endmodule

// File: tb/tb_vga_scanout_timing.sv
// Bench for vga_scanout_timing on a reduced 80x19 raster (64x12 visible) so complete frames stay short;
// lock settle, read latency and colour width keep their default values.
module tb_vga_scanout_timing;

  logic        clk, rst, locked;
  logic        rd_req;
  logic [9:0]  rd_x, rd_y;
  logic [23:0] rd_data;
  logic        vga_hs, vga_vs, vga_blank_n, vga_sync_n, frame_start;
  logic [7:0]  vga_r, vga_g, vga_b;
`ifdef VGA_TEST_PATTERN_EN
  logic        test_en;
`endif

  vga_scanout_timing #(
    .H_ACTIVE(64), .H_FP(4), .H_SYNC(8), .H_BP(4),
    .V_ACTIVE(12), .V_FP(2), .V_SYNC(2), .V_BP(3),
    .LOCK_SETTLE(16), .RD_LATENCY(2), .COLOR_W(8)
  ) dut (
    .clk(clk), .rst(rst), .locked(locked),
`ifdef VGA_TEST_PATTERN_EN
    .test_en(test_en),
`endif
    .rd_req(rd_req), .rd_x(rd_x), .rd_y(rd_y), .rd_data(rd_data),
    .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_blank_n(vga_blank_n), .vga_sync_n(vga_sync_n),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b), .frame_start(frame_start)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int t0    = 0;
  bit mon_on = 1'b0;
  bit sb_en  = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_idle(input string name);
    chk(name, {rd_req, rd_x, rd_y, vga_hs, vga_vs, vga_blank_n, vga_sync_n, vga_r, vga_g, vga_b, frame_start},
        {1'b0, 20'd0, 4'b1100, 24'd0, 1'b0});
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_req(output int n, input int limit);
    n = 0;
    do begin
      step();
      n++;
    end while (!rd_req && n < limit);
  endtask

  // ---------------- frame-buffer model and scoreboard ----------------
  logic [20:0] p1 = '0, p2 = '0;
  logic [23:0] exp_q[$];

  always @(posedge clk) begin
    p1 <= {rd_req, rd_x, rd_y};
    p2 <= p1;
    if (rd_req && sb_en) exp_q.push_back({rd_x[7:0], rd_y[7:0], 8'hA5});
  end

  assign rd_data = p2[20] ? {p2[17:10], p2[7:0], 8'hA5} : 24'h5A5A5A;

  always @(negedge clk) begin
    if (sb_en && vga_blank_n === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_pixel: got visible pixel %0h want no pixel (cycle %0d)", {vga_r, vga_g, vga_b}, cyc);
      end else begin
        chk("sb_pixel", {vga_r, vga_g, vga_b}, exp_q.pop_front());
      end
    end
  end

  // ---------------- free-run monitor over two frames ----------------
  int req_f0 = 0, req_f1 = 0, bl_cnt = 0, fs_cnt = 0, hs_falls = 0, vs_falls = 0;
  int hs_fall_t = -1, vs_fall_t = -1, fs_t = -1;
  logic hs_prev = 1'b1, vs_prev = 1'b1;

  always @(negedge clk) begin : free_run_mon
    int k;
    k = cyc - t0;
    if (mon_on && k <= 3042) begin
      if (rd_req && k < 3040) begin
        if (k < 1520) req_f0++;
        else          req_f1++;
      end
      if (vga_blank_n) bl_cnt++;
      if (hs_prev && !vga_hs) begin
        if (hs_fall_t >= 0) chk("hs_period", k - hs_fall_t, 80);
        hs_fall_t = k;
        hs_falls++;
      end
      if (!hs_prev && vga_hs && hs_fall_t >= 0) chk("hs_low_width", k - hs_fall_t, 8);
      if (vs_prev && !vga_vs) begin
        if (vs_fall_t >= 0) chk("vs_period", k - vs_fall_t, 1520);
        vs_fall_t = k;
        vs_falls++;
      end
      if (!vs_prev && vga_vs && vs_fall_t >= 0) chk("vs_low_width", k - vs_fall_t, 160);
      if (frame_start) begin
        if (fs_t >= 0) chk("fs_period", k - fs_t, 1520);
        fs_t = k;
        fs_cnt++;
      end
      hs_prev = vga_hs;
      vs_prev = vga_vs;
    end
  end

  // ---------------- directed vector table ----------------
  typedef struct {
    int          k;
    bit          pin;
    logic        req;
    logic [9:0]  x;
    logic [9:0]  y;
    logic        hs;
    logic        vs;
    logic        bl;
    logic        fs;
    logic [23:0] rgb;
  } vec_t;

  vec_t vq[$];

  function automatic void add_r(int k, logic req, int x, int y);
    vec_t v;
    v = '{k: k, pin: 1'b0, req: req, x: 10'(x), y: 10'(y), hs: 1'b1, vs: 1'b1, bl: 1'b0, fs: 1'b0, rgb: 24'h0};
    vq.push_back(v);
  endfunction

  function automatic void add_p(int k, logic hs, logic vs, logic bl, logic fs, logic [23:0] rgb);
    vec_t v;
    v = '{k: k, pin: 1'b1, req: 1'b0, x: 10'd0, y: 10'd0, hs: hs, vs: vs, bl: bl, fs: fs, rgb: rgb};
    vq.push_back(v);
  endfunction

  initial begin : watchdog
    #1000000;
    total++;
    bad++;
    $display("FAIL watchdog: got time limit want test end");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // ---------------- main sequence ----------------
  initial begin : main
    int n;
    bit saw_req;

    // Offsets k are cycles after the first rd_req for pixel (0,0).
    add_r(0, 1, 0, 0);
    add_p(2, 1, 1, 0, 0, 24'h000000);
    add_p(3, 1, 1, 1, 1, 24'h0000A5);
    add_p(4, 1, 1, 1, 0, 24'h0100A5);
    add_r(63, 1, 63, 0);
    add_r(64, 0, 64, 0);
    add_p(66, 1, 1, 1, 0, 24'h3F00A5);
    add_p(67, 1, 1, 0, 0, 24'h000000);
    add_p(70, 1, 1, 0, 0, 24'h000000);
    add_p(71, 0, 1, 0, 0, 24'h000000);
    add_p(78, 0, 1, 0, 0, 24'h000000);
    add_p(79, 1, 1, 0, 0, 24'h000000);
    add_r(80, 1, 0, 1);
    add_p(83, 1, 1, 1, 0, 24'h0001A5);
    add_r(943, 1, 63, 11);
    add_p(946, 1, 1, 1, 0, 24'h3F0BA5);
    add_p(947, 1, 1, 0, 0, 24'h000000);
    add_r(960, 0, 0, 12);
    add_p(1122, 1, 1, 0, 0, 24'h000000);
    add_p(1123, 1, 0, 0, 0, 24'h000000);
    add_p(1282, 1, 0, 0, 0, 24'h000000);
    add_p(1283, 1, 1, 0, 0, 24'h000000);
    add_r(1519, 0, 79, 18);
    add_r(1520, 1, 0, 0);
    add_p(1522, 1, 1, 0, 0, 24'h000000);
    add_p(1523, 1, 1, 1, 1, 24'h0000A5);

    rst = 1'b1;
    locked = 1'b1;
`ifdef VGA_TEST_PATTERN_EN
    test_en = 1'b0;
`endif
    repeat (5) begin
      step();
      check_idle("reset_idle");
    end
    rst = 1'b0;
    locked = 1'b0;
    repeat (4) begin
      step();
      check_idle("unlocked_idle");
    end

    // Lock acquisition and the first two frames.
    locked = 1'b1;
    wait_req(n, 60);
    chk("lock_to_first_req", n, 18);
    chk("first_req_xy", {rd_x, rd_y}, 20'd0);
    t0 = cyc;
    mon_on = 1'b1;

    foreach (vq[i]) begin
      while (cyc < t0 + vq[i].k) @(negedge clk);
      if (vq[i].pin)
        chk($sformatf("pin_vec%0d_k%0d", i, vq[i].k),
            {vga_hs, vga_vs, vga_blank_n, frame_start, vga_r, vga_g, vga_b},
            {vq[i].hs, vq[i].vs, vq[i].bl, vq[i].fs, vq[i].rgb});
      else
        chk($sformatf("rd_vec%0d_k%0d", i, vq[i].k), {rd_req, rd_x, rd_y}, {vq[i].req, vq[i].x, vq[i].y});
    end

    while (cyc < t0 + 3043) @(negedge clk);
    mon_on = 1'b0;
    chk("req_count_frame0", req_f0, 768);
    chk("req_count_frame1", req_f1, 768);
    chk("blank_n_count", bl_cnt, 1536);
    chk("frame_start_count", fs_cnt, 2);
    chk("hs_fall_count", hs_falls, 38);
    chk("vs_fall_count", vs_falls, 2);

    // Lock loss mid-frame at pixel (30,5).
    n = 0;
    while (!(rd_req && rd_x == 10'd30 && rd_y == 10'd5) && n < 4000) begin
      @(negedge clk);
      n++;
    end
    chk("drop_point_reached", n < 4000, 1'b1);
    locked = 1'b0;
    repeat (3) step();
    check_idle("drop_idle_3");
    exp_q.delete();
    repeat (4) step();
    check_idle("drop_idle_7");

    // One-cycle lock glitch during SETTLE restarts the settle count.
    locked = 1'b1;
    saw_req = 1'b0;
    repeat (10) begin
      step();
      if (rd_req) saw_req = 1'b1;
    end
    locked = 1'b0;
    step();
    if (rd_req) saw_req = 1'b1;
    locked = 1'b1;
    chk("no_req_before_glitch", saw_req, 1'b0);
    wait_req(n, 60);
    chk("settle_restart_to_req", n, 18);
    chk("relock_first_xy", {rd_x, rd_y}, 20'd0);
    repeat (3) step();
    chk("relock_frame_start", {frame_start, vga_blank_n, vga_hs, vga_vs}, 4'b1111);

`ifdef VGA_TEST_PATTERN_EN
    // Colour bars: 8 bars of 8 pixels on this raster.
    sb_en = 1'b0;
    exp_q.delete();
    test_en = 1'b1;
    step();
    n = 0;
    while (!frame_start && n < 4000) begin
      step();
      n++;
    end
    chk("tp_frame_start_seen", n < 4000, 1'b1);
    chk("tp_x0", {rd_req, vga_blank_n, vga_r, vga_g, vga_b}, {2'b01, 24'h000000});
    saw_req = 1'b0;
    for (int m = 1; m <= 68; m++) begin
      step();
      if (rd_req) saw_req = 1'b1;
      if (m == 7)  chk("tp_x7",  {vga_blank_n, vga_r, vga_g, vga_b}, {1'b1, 24'h000000});
      if (m == 8)  chk("tp_x8",  {vga_blank_n, vga_r, vga_g, vga_b}, {1'b1, 24'h0000FF});
      if (m == 16) chk("tp_x16", {vga_blank_n, vga_r, vga_g, vga_b}, {1'b1, 24'h00FF00});
      if (m == 56) chk("tp_x56", {vga_blank_n, vga_r, vga_g, vga_b}, {1'b1, 24'hFFFFFF});
      if (m == 63) chk("tp_x63", {vga_blank_n, vga_r, vga_g, vga_b}, {1'b1, 24'hFFFFFF});
      if (m == 64) chk("tp_x64_blank", {vga_blank_n, vga_r, vga_g, vga_b}, {1'b0, 24'h000000});
      if (m == 67) chk("tp_hs_before", vga_hs, 1'b1);
      if (m == 68) chk("tp_hs_fall", vga_hs, 1'b0);
    end
    chk("tp_no_rd_req", saw_req, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
